pipe_addsub: RTL
================

PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand and result width in bits.
REQ-002 The block SHALL have parameter SEG, default 4, bits per pipeline segment; WIDTH SHALL be an integer multiple of SEG.
REQ-003 The block SHALL derive NSEG = WIDTH/SEG, the pipeline depth in cycles.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operand set present this cycle.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 x  input  WIDTH  first operand.
REQ-009 y  input  WIDTH  second operand.
REQ-010 c_in  input  1  carry-in for add; borrow-in for subtract.
REQ-011 sub  input  1  0 = add, 1 = subtract.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts result this cycle.
REQ-014 s  output  WIDTH  sum or difference.
REQ-015 c_out  output  1  raw carry out of bit WIDTH-1; in subtract mode 1 = no borrow.
REQ-016 overflow  output  1  signed overflow, carry into MSB XOR carry out of MSB.
REQ-017 zero  output  1  s equals 0.

Function
REQ-018 Add: s,c_out SHALL equal x + y + c_in, truncated to WIDTH, carry to c_out.
REQ-019 Subtract: the block SHALL compute x + ~y + ~c_in, i.e. x - y - c_in, with c_out = NOT borrow.
REQ-020 The carry chain SHALL be split into NSEG segments of SEG bits; segment k SHALL be resolved in pipeline stage k, with the inter-segment carry registered between stages.
REQ-021 Operand bits for segment k SHALL be delayed k stages (input skew); completed sum bits SHALL be delayed so all WIDTH bits arrive together (output deskew).
REQ-022 Global advance = !out_valid || out_ready; all stage registers and valid bits SHALL update only when advance = 1.
REQ-023 in_ready SHALL equal advance; a transfer occurs when in_valid && in_ready.
REQ-024 Latency SHALL be exactly NSEG cycles from accepting edge to out_valid = 1 when advance stays 1.
REQ-025 Throughput SHALL be one operation per cycle with no stall.
REQ-026 Bubbles (in_valid = 0 on accept) SHALL propagate as valid = 0 without corrupting neighbouring results.
REQ-027 While out_valid && !out_ready, s, c_out, overflow, zero SHALL hold stable and no in-flight result SHALL be lost or reordered.
REQ-028 Results SHALL leave in acceptance order.
REQ-029 overflow and zero SHALL be registered with s and valid only when out_valid = 1.
REQ-030 NSEG = 1 SHALL degenerate to a single registered full-width adder with latency 1.

Reset
REQ-031 While rst = 1: all valid bits, s, c_out, overflow, zero SHALL be 0, independent of clk.
REQ-032 After rst deasserts, in_ready SHALL be 1 and out_valid 0.
REQ-033 Reset mid-operation SHALL discard all in-flight operations; none SHALL emerge afterwards.

Verification (WIDTH=16, SEG=4, NSEG=4 unless stated)
REQ-034 add, x=0x7FFF, y=0x0001, c_in=0, out_ready=1 -> 4 cycles later s=0x8000, c_out=0, overflow=1, zero=0.
REQ-035 add, x=0xFFFF, y=0x0001, c_in=0 -> s=0x0000, c_out=1, overflow=0, zero=1; carry ripples through all 4 stages.
REQ-036 sub, x=0x0005, y=0x0007, c_in=0 -> s=0xFFFE, c_out=0, overflow=0; sub, x=0x8000, y=0x0001 -> s=0x7FFF, c_out=1, overflow=1.
REQ-037 8 back-to-back random ops, out_ready low 3 cycles mid-stream -> in_ready=0 during stall, outputs held, all 8 results correct and in order, no duplicates.
REQ-038 rst pulsed with 3 ops in flight -> out_valid=0 immediately, no stale result after reset, next op returns correct after 4 cycles.
REQ-039 WIDTH=8, SEG=8 -> latency 1; 0x7F+0x01 gives s=0x80, overflow=1.

Source files
------------

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
// The master side drives operands and out_ready; the slave side is the adder.
interface pipe_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, x, y, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, overflow, zero
  );

  modport slave (
    input  in_valid, x, y, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, overflow, zero
  );
endinterface

// File: rtl/pipe_addsub.sv
// Segmented carry-pipelined adder/subtractor: one SEG-bit carry segment per
// stage, WIDTH/SEG stages deep, with a single global advance for backpressure.
module pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic         clk,
  input  logic         rst,
  pipe_addsub_if.slave bus
);
  // WIDTH must be an integer multiple of SEG.
  localparam int NSEG = WIDTH / SEG;

  typedef logic [WIDTH-1:0] word_t;

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           ci);
    return {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
  endfunction

  // Same-sign operands producing an opposite-sign result is exactly
  // carry-into-MSB XOR carry-out-of-MSB.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic            advance;
  word_t           a_in;
  word_t           b_in;
  logic            ci_in;

  word_t           a_p   [NSEG];
  word_t           b_p   [NSEG];
  word_t           sum_p [NSEG];
  logic            cy_p  [NSEG];
  logic [NSEG-1:0] vld_p;

  word_t           nxt_a   [NSEG];
  word_t           nxt_b   [NSEG];
  word_t           nxt_sum [NSEG];
  logic            nxt_cy  [NSEG];
  logic [NSEG-1:0] vld_in;
  logic [SEG:0]    seg_r;
  word_t           acc;

  logic            ovf_in;
  logic            zero_in;

  word_t           s_p;
  logic            c_out_p;
  logic            ovf_p;
  logic            zero_p;

  assign advance = !vld_p[NSEG-1] || bus.out_ready;

  // Subtract is x + ~y + ~borrow_in; the carry chain never knows the mode.
  assign a_in  = bus.x;
  assign b_in  = bus.sub ? ~bus.y : bus.y;
  assign ci_in = bus.sub ? ~bus.c_in : bus.c_in;

  always_comb begin
    nxt_a   = '{default: '0};
    nxt_b   = '{default: '0};
    nxt_sum = '{default: '0};
    nxt_cy  = '{default: 1'b0};
    vld_in  = '0;

    // stage 0: lowest segment straight from the operand inputs
    seg_r             = seg_add(a_in[SEG-1:0], b_in[SEG-1:0], ci_in);
    acc               = '0;
    acc[SEG-1:0]      = seg_r[SEG-1:0];
    nxt_a[0]          = a_in;
    nxt_b[0]          = b_in;
    nxt_sum[0]        = acc;
    nxt_cy[0]         = seg_r[SEG];
    vld_in[0]         = bus.in_valid;

    // stage k: segment k from skewed operands and the registered carry
    for (int k = 1; k < NSEG; k++) begin
      seg_r                = seg_add(a_p[k-1][k*SEG +: SEG],
                                     b_p[k-1][k*SEG +: SEG],
                                     cy_p[k-1]);
      acc                  = sum_p[k-1];
      acc[k*SEG +: SEG]    = seg_r[SEG-1:0];
      nxt_a[k]             = a_p[k-1];
      nxt_b[k]             = b_p[k-1];
      nxt_sum[k]           = acc;
      nxt_cy[k]            = seg_r[SEG];
      vld_in[k]            = vld_p[k-1];
    end
  end

  assign ovf_in  = signed_ovf(nxt_a[NSEG-1][WIDTH-1], nxt_b[NSEG-1][WIDTH-1],
                              nxt_sum[NSEG-1][WIDTH-1]);
  assign zero_in = (nxt_sum[NSEG-1] == '0);

  // valid chain and output stage (the last segment's stage register)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p   <= '0;
      s_p     <= '0;
      c_out_p <= 1'b0;
      ovf_p   <= 1'b0;
      zero_p  <= 1'b0;
    end else if (advance) begin
      vld_p <= vld_in;
      if (vld_in[NSEG-1]) begin
        s_p     <= nxt_sum[NSEG-1];
        c_out_p <= nxt_cy[NSEG-1];
        ovf_p   <= ovf_in;
        zero_p  <= zero_in;
      end else begin
        s_p     <= '0;
        c_out_p <= 1'b0;
        ovf_p   <= 1'b0;
        zero_p  <= 1'b0;
      end
    end
  end

  // inner stages: operand skew, partial sums and inter-segment carries
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < NSEG - 1; k++) begin
        a_p[k]   <= nxt_a[k];
        b_p[k]   <= nxt_b[k];
        sum_p[k] <= nxt_sum[k];
        cy_p[k]  <= nxt_cy[k];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_p[NSEG-1];
  assign bus.s         = s_p;
  assign bus.c_out     = c_out_p;
  assign bus.overflow  = ovf_p;
  assign bus.zero      = zero_p;
endmodule
